load_resp_unit: RTL and testbench

LOAD_RESP_UNIT -- requirements
Module: load_resp_unit

---
 rtl/load_resp_unit.sv | 184 ++++++++++++++++++
 tb/tb_load_resp_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_resp_unit.sv
// Load response unit: issues aligned data-bus reads for pipeline loads, extracts and
// extends the addressed byte/half/word, and reports address errors without touching the bus.
package load_resp_pkg;
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;
endpackage

// state | meaning
// IDLE  | ready for a new load request
// REQ   | read request presented on the data bus, waiting for addr_ok
// WAIT  | address accepted by the bus, waiting for read data
// DONE  | result (or address error) presented to the consumer
// DRAIN | flushed after the bus took the address; swallow the orphan read data
module load_resp_unit
    import load_resp_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,

    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  msize_t      req_msize,
    input  logic        req_unsigned,
    output logic        req_ready,

    output logic        dreq_valid,
    output logic [31:0] dreq_addr,
    output msize_t      dreq_size,
    output logic [3:0]  dreq_strobe,

    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [31:0] dresp_data,

    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_misalign,
    output logic [31:0] rsp_badvaddr,

    input  logic        rsp_ready,
    input  logic        flush
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    logic [2:0]  state_q,    state_d;
    logic [31:0] addr_q,     addr_d;
    msize_t      msize_q,    msize_d;
    logic        uns_q,      uns_d;
    logic [31:0] data_q,     data_d;
    logic        misalign_q, misalign_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    function automatic logic is_misaligned(input msize_t size, input logic [1:0] off);
        logic bad;
        case (size)
            MSIZE1:  bad = 1'b0;
            MSIZE2:  bad = off[0];
            MSIZE4:  bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte lanes follow the low address bits of the aligned word.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                            input msize_t size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            MSIZE1:  r = {{24{~uns & b[7]}}, b};
            MSIZE2:  r = {{16{~uns & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    logic [31:0] extracted;
    assign extracted = extract(dresp_data, addr_q[1:0], msize_q, uns_q);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        msize_d    = msize_q;
        uns_d      = uns_q;
        data_d     = data_q;
        misalign_d = misalign_q;
        badvaddr_d = badvaddr_q;

        case (state_q)
            IDLE: begin
                if (!flush && req_valid) begin
                    addr_d  = req_addr;
                    msize_d = req_msize;
                    uns_d   = req_unsigned;
                    if (is_misaligned(req_msize, req_addr[1:0])) begin
                        misalign_d = 1'b1;
                        badvaddr_d = req_addr;
                        data_d     = 32'h0;
                        state_d    = DONE;
                    end else begin
                        misalign_d = 1'b0;
                        badvaddr_d = 32'h0;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                if (flush) begin
                    // Once the bus has taken the address, its data beat must still be consumed.
                    if (dresp_addr_ok && !dresp_data_ok) state_d = DRAIN;
                    else                                 state_d = IDLE;
                end else if (dresp_addr_ok) begin
                    if (dresp_data_ok) begin
                        data_d  = extracted;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dresp_data_ok) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        data_d  = extracted;
                        state_d = DONE;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                if (flush || rsp_ready) state_d = IDLE;
            end
            DRAIN: begin
                if (dresp_data_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            addr_q     <= 32'h0;
            msize_q    <= MSIZE1;
            uns_q      <= 1'b0;
            data_q     <= 32'h0;
            misalign_q <= 1'b0;
            badvaddr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            msize_q    <= msize_d;
            uns_q      <= uns_d;
            data_q     <= data_d;
            misalign_q <= misalign_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign dreq_valid   = (state_q == REQ);
    assign dreq_addr    = addr_q;
    assign dreq_size    = msize_q;
    assign dreq_strobe  = 4'h0;
    assign rsp_valid    = (state_q == DONE);
    assign rsp_data     = data_q;
    assign rsp_misalign = misalign_q;
    assign rsp_badvaddr = badvaddr_q;

endmodule

// File: tb/tb_load_resp_unit.sv
// Directed bench for load_resp_unit: extraction, handshakes, misalign, flush and reset paths.
module tb_load_resp_unit;
    import load_resp_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = 32'h0;
    msize_t      req_msize = MSIZE1;
    logic        req_unsigned = 1'b0;
    logic        req_ready;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    msize_t      dreq_size;
    logic [3:0]  dreq_strobe;
    logic        dresp_addr_ok = 1'b0;
    logic        dresp_data_ok = 1'b0;
    logic [31:0] dresp_data = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_misalign;
    logic [31:0] rsp_badvaddr;
    logic        rsp_ready = 1'b0;
    logic        flush = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    load_resp_unit dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_addr(req_addr), .req_msize(req_msize),
        .req_unsigned(req_unsigned), .req_ready(req_ready),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_misalign(rsp_misalign),
        .rsp_badvaddr(rsp_badvaddr),
        .rsp_ready(rsp_ready), .flush(flush)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a request, answer with addr_ok+data_ok together, sample DONE, then retire it.
    task automatic do_load(input logic [31:0] addr, input msize_t size, input logic uns,
                           input logic [31:0] data,
                           output logic got_valid, output logic [31:0] got_data,
                           output logic got_mis);
        req_valid = 1'b1; req_addr = addr; req_msize = size; req_unsigned = uns;
        tick();
        req_valid = 1'b0;
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = data;
        tick();
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        got_valid = rsp_valid; got_data = rsp_data; got_mis = rsp_misalign;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_total++; if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", req_ready); else n_pass++;
        n_total++; if (dreq_valid !== 1'b0) $display("FAIL rst_dreq_valid: got %b want 0", dreq_valid); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
        n_total++; if (rsp_misalign !== 1'b0) $display("FAIL rst_misalign: got %b want 0", rsp_misalign); else n_pass++;
        n_total++; if (rsp_data !== 32'h0) $display("FAIL rst_rsp_data: got %h want 0", rsp_data); else n_pass++;
        n_total++; if (rsp_badvaddr !== 32'h0) $display("FAIL rst_badvaddr: got %h want 0", rsp_badvaddr); else n_pass++;
        n_total++; if (dreq_addr !== 32'h0) $display("FAIL rst_dreq_addr: got %h want 0", dreq_addr); else n_pass++;
        n_total++; if (dreq_strobe !== 4'h0) $display("FAIL rst_strobe: got %h want 0", dreq_strobe); else n_pass++;
        tick();
        tick();
        n_total++; if (dreq_valid !== 1'b0) $display("FAIL rst_clocked_dreq: got %b want 0", dreq_valid); else n_pass++;
        resetn = 1'b1;
    endtask

    task automatic test_signed_byte();
        req_valid = 1'b1; req_addr = 32'h1003; req_msize = MSIZE1; req_unsigned = 1'b0;
        n_total++; if (req_ready !== 1'b1) $display("FAIL sb_ready: got %b want 1", req_ready); else n_pass++;
        tick();
        req_valid = 1'b0;
        n_total++; if (dreq_valid !== 1'b1) $display("FAIL sb_dreq_valid: got %b want 1", dreq_valid); else n_pass++;
        n_total++; if (dreq_addr !== 32'h1003) $display("FAIL sb_dreq_addr: got %h want 1003", dreq_addr); else n_pass++;
        n_total++; if (dreq_size !== MSIZE1) $display("FAIL sb_dreq_size: got %0d want 0", dreq_size); else n_pass++;
        n_total++; if (req_ready !== 1'b0) $display("FAIL sb_busy: got %b want 0", req_ready); else n_pass++;
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h80AA5511;
        tick();
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        n_total++; if (rsp_valid !== 1'b1) $display("FAIL sb_rsp_valid: got %b want 1", rsp_valid); else n_pass++;
        n_total++; if (rsp_data !== 32'hFFFFFF80) $display("FAIL sb_rsp_data: got %h want ffffff80", rsp_data); else n_pass++;
        n_total++; if (rsp_misalign !== 1'b0) $display("FAIL sb_misalign: got %b want 0", rsp_misalign); else n_pass++;
        n_total++; if (dreq_valid !== 1'b0) $display("FAIL sb_dreq_drop: got %b want 0", dreq_valid); else n_pass++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL sb_retire: got %b want 0", rsp_valid); else n_pass++;
        n_total++; if (req_ready !== 1'b1) $display("FAIL sb_idle: got %b want 1", req_ready); else n_pass++;
    endtask

    task automatic test_misalign();
        req_valid = 1'b1; req_addr = 32'h3001; req_msize = MSIZE4; req_unsigned = 1'b0;
        tick();
        req_valid = 1'b0;
        n_total++; if (rsp_valid !== 1'b1) $display("FAIL ma_rsp_valid: got %b want 1", rsp_valid); else n_pass++;
        n_total++; if (rsp_misalign !== 1'b1) $display("FAIL ma_flag: got %b want 1", rsp_misalign); else n_pass++;
        n_total++; if (rsp_badvaddr !== 32'h3001) $display("FAIL ma_badvaddr: got %h want 3001", rsp_badvaddr); else n_pass++;
        n_total++; if (rsp_data !== 32'h0) $display("FAIL ma_data: got %h want 0", rsp_data); else n_pass++;
        n_total++; if (dreq_valid !== 1'b0) $display("FAIL ma_no_bus: got %b want 0", dreq_valid); else n_pass++;
        dresp_data_ok = 1'b1; dresp_data = 32'hCAFEF00D;
        tick();
        dresp_data_ok = 1'b0;
        n_total++; if (rsp_data !== 32'h0) $display("FAIL ma_done_ignores_data: got %h want 0", rsp_data); else n_pass++;
        n_total++; if (rsp_valid !== 1'b1) $display("FAIL ma_hold: got %b want 1", rsp_valid); else n_pass++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_total++; if (dreq_valid !== 1'b0) $display("FAIL ma_no_bus_after: got %b want 0", dreq_valid); else n_pass++;
        req_valid = 1'b1; req_addr = 32'h3005; req_msize = MSIZE2;
        tick();
        req_valid = 1'b0;
        n_total++; if (rsp_misalign !== 1'b1) $display("FAIL ma_half_odd: got %b want 1", rsp_misalign); else n_pass++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h3008; req_msize = msize_t'(2'd3);
        tick();
        req_valid = 1'b0;
        n_total++; if (rsp_misalign !== 1'b1) $display("FAIL ma_bad_size: got %b want 1", rsp_misalign); else n_pass++;
        n_total++; if (rsp_badvaddr !== 32'h3008) $display("FAIL ma_bad_size_addr: got %h want 3008", rsp_badvaddr); else n_pass++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_extract();
        logic v, m;
        logic [31:0] d;
        do_load(32'h2002, MSIZE2, 1'b1, 32'hBEEF1234, v, d, m);
        n_total++; if (v !== 1'b1) $display("FAIL uh_valid: got %b want 1", v); else n_pass++;
        n_total++; if (d !== 32'h0000BEEF) $display("FAIL uh_data: got %h want 0000beef", d); else n_pass++;
        n_total++; if (m !== 1'b0) $display("FAIL uh_misalign: got %b want 0", m); else n_pass++;
        do_load(32'h2000, MSIZE2, 1'b0, 32'h12348001, v, d, m);
        n_total++; if (d !== 32'hFFFF8001) $display("FAIL sh_data: got %h want ffff8001", d); else n_pass++;
        do_load(32'h2001, MSIZE1, 1'b1, 32'h0000C300, v, d, m);
        n_total++; if (d !== 32'h000000C3) $display("FAIL ub_data: got %h want 000000c3", d); else n_pass++;
        do_load(32'h2006, MSIZE1, 1'b0, 32'h007F0000, v, d, m);
        n_total++; if (d !== 32'h0000007F) $display("FAIL sb_pos_data: got %h want 0000007f", d); else n_pass++;
    endtask

    task automatic test_split();
        req_valid = 1'b1; req_addr = 32'h4000; req_msize = MSIZE4; req_unsigned = 1'b0;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (dreq_valid !== 1'b1 || dreq_addr !== 32'h4000 || dreq_size !== MSIZE4)
                $display("FAIL split_hold%0d: got v=%b a=%h s=%0d want v=1 a=4000 s=2", i, dreq_valid, dreq_addr, dreq_size);
            else n_pass++;
            tick();
        end
        n_total++; if (dreq_valid !== 1'b1) $display("FAIL split_hold3: got %b want 1", dreq_valid); else n_pass++;
        dresp_addr_ok = 1'b1;
        tick();
        dresp_addr_ok = 1'b0;
        n_total++; if (dreq_valid !== 1'b0) $display("FAIL split_wait_dreq: got %b want 0", dreq_valid); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL split_wait_rsp: got %b want 0", rsp_valid); else n_pass++;
        tick();
        dresp_data_ok = 1'b1; dresp_data = 32'h12345678;
        tick();
        dresp_data_ok = 1'b0;
        n_total++; if (rsp_valid !== 1'b1) $display("FAIL split_rsp_valid: got %b want 1", rsp_valid); else n_pass++;
        n_total++; if (rsp_data !== 32'h12345678) $display("FAIL split_data: got %h want 12345678", rsp_data); else n_pass++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_flush_wait();
        logic v, m;
        logic [31:0] d;
        req_valid = 1'b1; req_addr = 32'h5000; req_msize = MSIZE4;
        tick();
        req_valid = 1'b0;
        dresp_addr_ok = 1'b1;
        tick();
        dresp_addr_ok = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_total++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || dreq_valid !== 1'b0)
            $display("FAIL fw_drain: got rdy=%b rv=%b dv=%b want 0 0 0", req_ready, rsp_valid, dreq_valid);
        else n_pass++;
        tick();
        n_total++; if (req_ready !== 1'b0) $display("FAIL fw_drain_hold: got %b want 0", req_ready); else n_pass++;
        dresp_data_ok = 1'b1; dresp_data = 32'hDEADBEEF;
        tick();
        dresp_data_ok = 1'b0;
        n_total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL fw_consumed: got rdy=%b rv=%b want 1 0", req_ready, rsp_valid);
        else n_pass++;
        do_load(32'h5004, MSIZE4, 1'b0, 32'h0BADF00D, v, d, m);
        n_total++; if (v !== 1'b1 || d !== 32'h0BADF00D)
            $display("FAIL fw_next: got v=%b d=%h want v=1 d=0badf00d", v, d);
        else n_pass++;
    endtask

    task automatic test_flush_other();
        req_valid = 1'b1; req_addr = 32'h7000; req_msize = MSIZE4; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        n_total++; if (req_ready !== 1'b1 || dreq_valid !== 1'b0)
            $display("FAIL fl_idle_prio: got rdy=%b dv=%b want 1 0", req_ready, dreq_valid);
        else n_pass++;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        n_total++; if (req_ready !== 1'b1 || dreq_valid !== 1'b0)
            $display("FAIL fl_req_withdraw: got rdy=%b dv=%b want 1 0", req_ready, dreq_valid);
        else n_pass++;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b1;
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h11112222;
        tick();
        flush = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        n_total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL fl_req_both: got rdy=%b rv=%b want 1 0", req_ready, rsp_valid);
        else n_pass++;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b1; dresp_addr_ok = 1'b1;
        tick();
        dresp_addr_ok = 1'b0;
        tick();
        flush = 1'b0;
        n_total++; if (req_ready !== 1'b0) $display("FAIL fl_drain_ignores_flush: got %b want 0", req_ready); else n_pass++;
        dresp_data_ok = 1'b1;
        tick();
        dresp_data_ok = 1'b0;
        n_total++; if (req_ready !== 1'b1) $display("FAIL fl_drain_exit: got %b want 1", req_ready); else n_pass++;
        req_valid = 1'b1; req_addr = 32'h7002; req_msize = MSIZE4;
        tick();
        req_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        n_total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL fl_done_drop: got rv=%b rdy=%b want 0 1", rsp_valid, req_ready);
        else n_pass++;
    endtask

    task automatic test_backpressure_reset();
        req_valid = 1'b1; req_addr = 32'h6001; req_msize = MSIZE1; req_unsigned = 1'b0;
        tick();
        req_valid = 1'b0;
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h00007F00;
        tick();
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000007F)
                $display("FAIL bp_hold%0d: got v=%b d=%h want v=1 d=0000007f", i, rsp_valid, rsp_data);
            else n_pass++;
            dresp_data_ok = (i == 1); dresp_data = 32'hFFFFFFFF;
            tick();
            dresp_data_ok = 1'b0;
        end
        resetn = 1'b0;
        #1;
        n_total++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_misalign !== 1'b0)
            $display("FAIL bp_async_reset: got v=%b d=%h m=%b want 0 0 0", rsp_valid, rsp_data, rsp_misalign);
        else n_pass++;
        tick();
        resetn = 1'b1;
        req_valid = 1'b1; req_addr = 32'h6100; req_msize = MSIZE4;
        tick();
        req_valid = 1'b0; dresp_addr_ok = 1'b1;
        tick();
        dresp_addr_ok = 1'b0;
        resetn = 1'b0;
        #2;
        n_total++; if (dreq_valid !== 1'b0 || req_ready !== 1'b1 || dreq_addr !== 32'h0)
            $display("FAIL mid_reset: got dv=%b rdy=%b a=%h want 0 1 0", dreq_valid, req_ready, dreq_addr);
        else n_pass++;
        resetn = 1'b1;
        dresp_data_ok = 1'b1; dresp_data = 32'h55555555;
        tick();
        dresp_data_ok = 1'b0;
        n_total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== 32'h0)
            $display("FAIL late_data_ignored: got rv=%b rdy=%b d=%h want 0 1 0", rsp_valid, req_ready, rsp_data);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_signed_byte();
        test_misalign();
        test_extract();
        test_split();
        test_flush_wait();
        test_flush_other();
        test_backpressure_reset();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
